// File: rtl/timer_logic_ctrl_n.sv
// Per-channel control logic for a multi-channel 8-bit timer: counter-clear selection,
// sticky status flags with interrupt gating, waveform outputs, ADC trigger and clock select.
module timer_logic_ctrl_n #(
  parameter int                NUM_CH   = 2,
  parameter logic [NUM_CH-1:0] TMO_INIT = {NUM_CH{1'b0}},
  parameter int                ADC_CH   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     tmri,
  input  logic [8*NUM_CH-1:0]   tcr,
  input  logic [8*NUM_CH-1:0]   tccr,
  input  logic [8*NUM_CH-1:0]   tcsr,
  input  logic [3*NUM_CH-1:0]   flag_clr,
  input  logic [NUM_CH-1:0]     cmp_match_a,
  input  logic [NUM_CH-1:0]     cmp_match_b,
  input  logic [NUM_CH-1:0]     overflow,
  output logic [NUM_CH-1:0]     counter_clear,
  output logic [3*NUM_CH-1:0]   flags,
  output logic [NUM_CH-1:0]     cmia,
  output logic [NUM_CH-1:0]     cmib,
  output logic [NUM_CH-1:0]     ovi,
  output logic [NUM_CH-1:0]     tmo,
  output logic                  adc_request,
  output logic [5*NUM_CH-1:0]   clock_select
);

  logic [NUM_CH-1:0]   s1_q, s2_q, s3_q;
  logic [3*NUM_CH-1:0] flags_q, flags_d;
  logic [NUM_CH-1:0]   tmo_q, tmo_d;
  logic                adc_q, adc_d;

  // Waveform action codes: 01 drive low, 10 drive high, 11 toggle, 00 hold.
  function automatic logic tmo_action(input logic cur, input logic [1:0] code);
    case (code)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~cur;
      default: return cur;
    endcase
  endfunction

  always_comb begin
    flags_d       = flags_q;
    tmo_d         = tmo_q;
    counter_clear = '0;
    cmia          = '0;
    cmib          = '0;
    ovi           = '0;
    clock_select  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      case (tcr[8*ch+3 +: 2])
        2'b01:   counter_clear[ch] = cmp_match_a[ch];
        2'b10:   counter_clear[ch] = cmp_match_b[ch];
        2'b11:   counter_clear[ch] = tccr[8*ch+3] ? s2_q[ch] : (s2_q[ch] & ~s3_q[ch]);
        default: counter_clear[ch] = 1'b0;
      endcase

      // A new event wins over a coincident clear strobe.
      flags_d[3*ch +: 3] = (flags_q[3*ch +: 3] & ~flag_clr[3*ch +: 3])
                         | {cmp_match_b[ch], cmp_match_a[ch], overflow[ch]};

      ovi[ch]  = flags_q[3*ch]   & tcr[8*ch+5];
      cmia[ch] = flags_q[3*ch+1] & tcr[8*ch+6];
      cmib[ch] = flags_q[3*ch+2] & tcr[8*ch+7];

      // B has priority so a coincident A/B match never double-toggles.
      if (cmp_match_b[ch] && (tcsr[8*ch+2 +: 2] != 2'b00))
        tmo_d[ch] = tmo_action(tmo_q[ch], tcsr[8*ch+2 +: 2]);
      else if (cmp_match_a[ch] && (tcsr[8*ch +: 2] != 2'b00))
        tmo_d[ch] = tmo_action(tmo_q[ch], tcsr[8*ch +: 2]);

      clock_select[5*ch +: 5] = {tcr[8*ch +: 3], tccr[8*ch +: 2]};
    end
    adc_d = cmp_match_a[ADC_CH] & tcsr[8*ADC_CH+4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      flags_q <= '0;
      tmo_q   <= TMO_INIT;
      adc_q   <= 1'b0;
    end else begin
      s1_q    <= tmri;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      flags_q <= flags_d;
      tmo_q   <= tmo_d;
      adc_q   <= adc_d;
    end
  end

  assign flags       = flags_q;
  assign tmo         = tmo_q;
  assign adc_request = adc_q;

  // Register bits with no function in this block (ADTE matters only on ADC_CH).
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unused
    logic unused_ch;
    assign unused_ch = ^{tccr[8*g+4 +: 4], tccr[8*g+2], tcsr[8*g+5 +: 3], tcsr[8*g+4]};
  end

endmodule

// File: tb/tb_timer_logic_ctrl_n.sv
// Directed and randomized bench for timer_logic_ctrl_n against a behavioural model.
module tb_timer_logic_ctrl_n;
  localparam int                NUM_CH   = 2;
  localparam logic [NUM_CH-1:0] TMO_INIT = 2'b00;
  localparam int                ADC_CH   = 0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NUM_CH-1:0]   tmri;
  logic [8*NUM_CH-1:0] tcr, tccr, tcsr;
  logic [3*NUM_CH-1:0] flag_clr;
  logic [NUM_CH-1:0]   cmp_match_a, cmp_match_b, overflow;
  logic [NUM_CH-1:0]   counter_clear, cmia, cmib, ovi, tmo;
  logic [3*NUM_CH-1:0] flags;
  logic                adc_request;
  logic [5*NUM_CH-1:0] clock_select;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_idx  = 0;
  int cc_hits;
  int cc_first;

  logic [2:0]        m_flags [NUM_CH];
  logic [NUM_CH-1:0] m_tmo;
  logic              m_adc;
  logic [NUM_CH-1:0] tmri_hist [$];

  timer_logic_ctrl_n #(.NUM_CH(NUM_CH), .TMO_INIT(TMO_INIT), .ADC_CH(ADC_CH)) dut (
    .clk(clk), .rst_n(rst_n), .tmri(tmri), .tcr(tcr), .tccr(tccr), .tcsr(tcsr),
    .flag_clr(flag_clr), .cmp_match_a(cmp_match_a), .cmp_match_b(cmp_match_b),
    .overflow(overflow), .counter_clear(counter_clear), .flags(flags), .cmia(cmia),
    .cmib(cmib), .ovi(ovi), .tmo(tmo), .adc_request(adc_request), .clock_select(clock_select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic act(input logic cur, input int code);
    if (code == 1) return 1'b0;
    if (code == 2) return 1'b1;
    if (code == 3) return !cur;
    return cur;
  endfunction

  // tmri as sampled 'age' clock edges ago (0 = most recent sample).
  function automatic logic past_tmri(input int ch, input int age);
    if (tmri_hist.size() > age) return tmri_hist[age][ch];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) m_flags[ch] = 3'b000;
    m_tmo = TMO_INIT;
    m_adc = 1'b0;
    tmri_hist.delete();
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] nt;
    logic ev;
    int osa, osb;
    nt = m_tmo;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int b = 0; b < 3; b++) begin
        ev = (b == 0) ? overflow[ch] : (b == 1) ? cmp_match_a[ch] : cmp_match_b[ch];
        if (ev) m_flags[ch][b] = 1'b1;
        else if (flag_clr[3*ch+b]) m_flags[ch][b] = 1'b0;
      end
      osb = int'(tcsr[8*ch+2 +: 2]);
      osa = int'(tcsr[8*ch +: 2]);
      if (cmp_match_b[ch] && osb != 0) nt[ch] = act(m_tmo[ch], osb);
      else if (cmp_match_a[ch] && osa != 0) nt[ch] = act(m_tmo[ch], osa);
    end
    m_tmo = nt;
    m_adc = cmp_match_a[ADC_CH] & tcsr[8*ADC_CH+4];
    tmri_hist.push_front(tmri);
    if (tmri_hist.size() > 3) void'(tmri_hist.pop_back());
  endtask

  task automatic check_outputs();
    logic exp_cc;
    int mode;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mode = int'(tcr[8*ch+3 +: 2]);
      if (mode == 1) exp_cc = cmp_match_a[ch];
      else if (mode == 2) exp_cc = cmp_match_b[ch];
      else if (mode == 3 && tccr[8*ch+3]) exp_cc = past_tmri(ch, 1);
      else if (mode == 3) exp_cc = past_tmri(ch, 1) && !past_tmri(ch, 2);
      else exp_cc = 1'b0;
      chk($sformatf("counter_clear[%0d]", ch), counter_clear[ch], exp_cc);
      chk($sformatf("flags[%0d]", ch), flags[3*ch +: 3], m_flags[ch]);
      chk($sformatf("cmia[%0d]", ch), cmia[ch], m_flags[ch][1] & tcr[8*ch+6]);
      chk($sformatf("cmib[%0d]", ch), cmib[ch], m_flags[ch][2] & tcr[8*ch+7]);
      chk($sformatf("ovi[%0d]", ch), ovi[ch], m_flags[ch][0] & tcr[8*ch+5]);
      chk($sformatf("tmo[%0d]", ch), tmo[ch], m_tmo[ch]);
      chk($sformatf("clock_select[%0d]", ch), clock_select[5*ch +: 5],
          {tcr[8*ch +: 3], tccr[8*ch +: 2]});
    end
    chk("adc_request", adc_request, m_adc);
    if (counter_clear[0]) begin
      cc_hits++;
      if (cc_first < 0) cc_first = cyc_idx;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 ns later, then the model steps.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc_idx++;
  endtask

  task automatic idle();
    cmp_match_a = '0; cmp_match_b = '0; overflow = '0; flag_clr = '0;
  endtask

  initial begin
    logic exp_t;
    int base;
    rst_n = 1'b0;
    tmri = '1; tcr = 16'h1818; tccr = '0; tcsr = '0;
    flag_clr = '0; cmp_match_a = '0; cmp_match_b = '0; overflow = '0;
    cc_hits = 0; cc_first = -1;
    model_reset();
    #2;
    chk("reset_flags", flags, '0);
    chk("reset_tmo", tmo, TMO_INIT);
    chk("reset_adc", adc_request, 1'b0);
    chk("reset_counter_clear", counter_clear, '0);
    @(negedge clk);
    tmri = '0; tcr = '0;
    rst_n = 1'b1;
    repeat (3) cycle();

    // Ch0 toggle on compare-match A.
    tcsr = 16'h0003;
    exp_t = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      cmp_match_a[0] = (i > 0) && (i % 10 == 0);
      cycle();
      if ((i > 0) && (i % 10 == 0)) begin
        chk("req019_tmo0", tmo[0], exp_t);
        exp_t = ~exp_t;
      end
    end
    idle();

    // Ch1 B toggle beats A set; then A-only sets.
    tcsr = 16'h0E00;
    chk("req020_tmo1_pre", tmo[1], 1'b0);
    cmp_match_a[1] = 1'b1; cmp_match_b[1] = 1'b1;
    cycle();
    idle();
    chk("req020_tmo1_both", tmo[1], 1'b1);
    cycle();
    cmp_match_a[1] = 1'b1;
    cycle();
    idle();
    chk("req020_tmo1_a", tmo[1], 1'b1);
    cycle();

    // External clear, edge mode then level mode.
    tcsr = '0; tcr = 16'h0018; tccr = '0;
    cc_hits = 0; cc_first = -1; base = cyc_idx;
    for (int i = 0; i < 14; i++) begin
      tmri[0] = (i < 10);
      cycle();
    end
    chk("req021_edge_hits", cc_hits, 1);
    chk("req021_edge_delay", cc_first - base, 2);
    tccr = 16'h0008;
    cc_hits = 0; cc_first = -1; base = cyc_idx;
    for (int i = 0; i < 14; i++) begin
      tmri[0] = (i < 10);
      cycle();
    end
    chk("req021_level_hits", cc_hits, 10);
    chk("req021_level_delay", cc_first - base, 2);
    tcr = '0; tccr = '0;

    // Set beats clear; clear alone drops the interrupt.
    flag_clr = '1;
    cycle();
    idle();
    chk("flags_cleared", flags, '0);
    tcr = 16'h0040;
    cmp_match_a[0] = 1'b1; flag_clr[1] = 1'b1;
    cycle();
    idle();
    chk("req022_cmfa", flags[1], 1'b1);
    chk("req022_cmia_set", cmia[0], 1'b1);
    repeat (4) cycle();
    flag_clr[1] = 1'b1;
    cycle();
    idle();
    chk("req022_cmia_clr", cmia[0], 1'b0);

    // ADC trigger.
    tcsr = 16'h0010;
    cmp_match_a[0] = 1'b1;
    cycle();
    idle();
    chk("req023_adc_pulse", adc_request, 1'b1);
    cycle();
    chk("req023_adc_end", adc_request, 1'b0);
    tcsr = 16'h1000;
    cmp_match_a[0] = 1'b1;
    cycle();
    idle();
    chk("req023_adc_off", adc_request, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        tcr  = 16'($urandom());
        tccr = 16'($urandom());
        tcsr = 16'($urandom());
      end
      if ($urandom_range(0, 3) == 0) tmri = NUM_CH'($urandom());
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cmp_match_a[ch] = ($urandom_range(0, 3) == 0);
        cmp_match_b[ch] = ($urandom_range(0, 4) == 0);
        overflow[ch]    = ($urandom_range(0, 5) == 0);
      end
      for (int b = 0; b < 3*NUM_CH; b++) flag_clr[b] = ($urandom_range(0, 5) == 0);
      cycle();
    end
    idle();
    tmri = '0;

    // Asynchronous reset with flags and tmo set.
    tcr = '0; tccr = '0; tcsr = 16'h0002;
    cmp_match_a[0] = 1'b1; cmp_match_b[0] = 1'b1; overflow[0] = 1'b1;
    cycle();
    idle();
    chk("req024_flags_pre", flags[2:0], 3'b111);
    chk("req024_tmo_pre", tmo[0], 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("req024_flags_rst", flags, '0);
    chk("req024_tmo_rst", tmo, TMO_INIT);
    chk("req024_adc_rst", adc_request, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
